fft_sink_framer: RTL and testbench

Frames the continuous complex sample stream from `nco_signal` (`fsin_o`/`fcos_o`, qualified by `out_valid`) into fixed-length Avalon-ST packets for the FFT sink port of `fft_wrapper`. It drives `sink_sop`/`sink_eop`/`sink_valid` and absorbs FFT backpressure in a small FIFO. Frame boundaries are marked on the input side, so every emitted packet holds exactly `FRAME_LEN` samples.

---
 rtl/fft_pkg.sv | 21 ++
 rtl/framer_fifo.sv | 71 +++++++
 rtl/fft_sink_framer.sv | 124 ++++++++++++
 tb/tb_fft_sink_framer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT sink framer and its buffer.
package fft_pkg;

    localparam int SAMPLE_W = 14;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } framer_state_t;

    // Buffered beat layout; the framer packs its FIFO words in this order.
    typedef struct packed {
        logic                sop;
        logic                eop;
        logic [SAMPLE_W-1:0] sample_re;
        logic [SAMPLE_W-1:0] sample_im;
    } fifo_entry_t;

    localparam logic [1:0] SINK_ERR_NONE = 2'b00;

endpackage

// File: rtl/framer_fifo.sv
// First-word-fall-through FIFO with a registered head; the head register
// counts toward DEPTH, so at most DEPTH words are held in total.
module framer_fifo #(
    parameter int DW    = 30,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_i,
    output logic [DW-1:0] rd_data_o,
    output logic          rd_valid_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] mem_cnt_q;
    logic [CW-1:0] mem_cnt_d;
    logic [CW-1:0] total_cnt;
    logic [DW-1:0] head_q;
    logic          head_valid_q;
    logic          pop;
    logic          load;

    // The head refills from storage whenever it is empty or being consumed.
    assign pop       = head_valid_q & rd_i;
    assign load      = (mem_cnt_q != '0) & (~head_valid_q | pop);
    assign mem_cnt_d = mem_cnt_q + CW'(wr_i) - CW'(load);
    assign total_cnt = mem_cnt_q + CW'(head_valid_q);

    always_ff @(posedge clk) begin
        if (wr_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            mem_cnt_q    <= '0;
            head_q       <= '0;
            head_valid_q <= 1'b0;
        end else begin
            mem_cnt_q <= mem_cnt_d;
            if (wr_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (load) begin
                head_q       <= mem_q[rd_ptr_q];
                head_valid_q <= 1'b1;
                rd_ptr_q     <= rd_ptr_q + AW'(1);
            end else if (pop) begin
                head_valid_q <= 1'b0;
            end
        end
    end

    assign rd_data_o  = head_q;
    assign rd_valid_o = head_valid_q;
    assign full_o     = (total_cnt == CW'(DEPTH));
    assign empty_o    = (total_cnt == '0);

endmodule

// File: rtl/fft_sink_framer.sv
// Frames the NCO sample stream into FRAME_LEN-sample Avalon-ST packets.
// Define FRAMER_DROP_CNT_EN to add the saturating drop_cnt output.
module fft_sink_framer
    import fft_pkg::*;
#(
    parameter int W          = SAMPLE_W,
    parameter int FRAME_LEN  = 1024,
    parameter int FIFO_DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         in_valid,
    input  logic [W-1:0] in_real,
    input  logic [W-1:0] in_imag,
    input  logic         sink_ready,
    output logic         sink_valid,
    output logic [W-1:0] sink_real,
    output logic [W-1:0] sink_imag,
    output logic         sink_sop,
    output logic         sink_eop,
    output logic [1:0]   sink_error,
    output logic         overflow,
    output logic         busy
`ifdef FRAMER_DROP_CNT_EN
    ,
    output logic [15:0]  drop_cnt
`endif
);

    localparam int CNTW = $clog2(FRAME_LEN);
    localparam int DW   = 2 * W + 2;

    framer_state_t state_q;
    framer_state_t state_d;
    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;
    logic            overflow_q;
    logic            push_req;
    logic            push;
    logic            pop;
    logic            drop;
    logic            at_eop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [DW-1:0]   wr_data;
    logic [DW-1:0]   rd_data;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push_req = (state_q == RUN) & in_valid;
    assign pop      = sink_valid & sink_ready;
    assign push     = push_req & (~fifo_full | pop);
    assign drop     = push_req & ~push;
    assign at_eop   = (cnt_q == CNTW'(FRAME_LEN - 1));
    assign wr_data  = {(cnt_q == '0), at_eop, in_real, in_imag};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (push) begin
                    cnt_d = at_eop ? '0 : cnt_q + CNTW'(1);
                    if (at_eop && !en) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_q | drop;
        end
    end

    framer_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_i       (push),
        .wr_data_i  (wr_data),
        .rd_i       (sink_ready),
        .rd_data_o  (rd_data),
        .rd_valid_o (sink_valid),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign {sink_sop, sink_eop, sink_real, sink_imag} = rd_data;
    assign sink_error = SINK_ERR_NONE;
    assign overflow   = overflow_q;
    assign busy       = (state_q == RUN) | ~fifo_empty;

`ifdef FRAMER_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_q <= '0;
        end else if (drop && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fft_sink_framer.sv
// Directed bench for fft_sink_framer with FRAME_LEN=8 and FIFO_DEPTH=16.
module tb_fft_sink_framer;
    import fft_pkg::*;

    localparam int W  = SAMPLE_W;
    localparam int FL = 8;
    localparam int FD = 16;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         en;
    logic         in_valid;
    logic [W-1:0] in_real;
    logic [W-1:0] in_imag;
    logic         sink_ready;
    logic         sink_valid;
    logic [W-1:0] sink_real;
    logic [W-1:0] sink_imag;
    logic         sink_sop;
    logic         sink_eop;
    logic [1:0]   sink_error;
    logic         overflow;
    logic         busy;
`ifdef FRAMER_DROP_CNT_EN
    logic [15:0]  drop_cnt;
`endif

    fft_sink_framer #(
        .W          (W),
        .FRAME_LEN  (FL),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .in_valid   (in_valid),
        .in_real    (in_real),
        .in_imag    (in_imag),
        .sink_ready (sink_ready),
        .sink_valid (sink_valid),
        .sink_real  (sink_real),
        .sink_imag  (sink_imag),
        .sink_sop   (sink_sop),
        .sink_eop   (sink_eop),
        .sink_error (sink_error),
        .overflow   (overflow),
        .busy       (busy)
`ifdef FRAMER_DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic         inValid;
        logic [W-1:0] inRe;
        logic         expValid;
        logic         expSop;
        logic         expEop;
        logic [W-1:0] expRe;
    } vec_t;

    vec_t        vecs [26];
    fifo_entry_t beats [$];

    // Beats are captured mid-cycle, where inputs and outputs are settled.
    always @(negedge clk) begin
        if (reset_n && sink_valid && sink_ready) begin
            beats.push_back('{sop: sink_sop, eop: sink_eop,
                              sample_re: sink_real, sample_im: sink_imag});
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input int value, input logic rdy);
        in_valid   = v;
        in_real    = W'(value);
        in_imag    = ~W'(value);
        sink_ready = rdy;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        en      = 1'b0;
        applyStimulus(1'b0, 0, 1'b0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        beats.delete();
    endtask

    task automatic startRun();
        en = 1'b1;
        applyStimulus(1'b0, 0, 1'b1);
        tick();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 0, 1'b1);
            tick();
        end
    endtask

    // Compares the captured beats with an expected ramp split into frames.
    task automatic checkBeats(input string name, input int expected[$]);
        logic [W-1:0] expRe;
        checkOutput({name, " beat count"}, beats.size(), expected.size());
        for (int i = 0; i < beats.size() && i < expected.size(); i++) begin
            expRe = W'(expected[i]);
            checkOutput($sformatf("%s real[%0d]", name, i), beats[i].sample_re, expRe);
            checkOutput($sformatf("%s sop[%0d]", name, i), beats[i].sop, (i % FL) == 0);
            checkOutput($sformatf("%s eop[%0d]", name, i), beats[i].eop, (i % FL) == FL - 1);
        end
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, " valid"}, sink_valid, 0);
        checkOutput({name, " sop"}, sink_sop, 0);
        checkOutput({name, " eop"}, sink_eop, 0);
        checkOutput({name, " real"}, sink_real, 0);
        checkOutput({name, " imag"}, sink_imag, 0);
        checkOutput({name, " error"}, sink_error, 0);
        checkOutput({name, " overflow"}, overflow, 0);
        checkOutput({name, " busy"}, busy, 0);
`ifdef FRAMER_DROP_CNT_EN
        checkOutput({name, " drop_cnt"}, drop_cnt, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int exp[$];
        logic [W-1:0] expIm;

        // Ramp table: the sample pushed at edge k is the head after edge k+1.
        for (int k = 0; k < 26; k++) begin
            vecs[k].inValid  = (k < 24);
            vecs[k].inRe     = (k < 24) ? W'(k) : '0;
            vecs[k].expValid = (k >= 1) && (k <= 24);
            vecs[k].expRe    = (k >= 1) ? W'(k - 1) : '0;
            vecs[k].expSop   = vecs[k].expValid && (((k - 1) % FL) == 0);
            vecs[k].expEop   = vecs[k].expValid && (((k - 1) % FL) == FL - 1);
        end

        reset_n = 1'b0;
        en      = 1'b0;
        applyStimulus(1'b0, 0, 1'b0);
        #1;
        checkAllZero("reset");
        doReset();

        $display("[TB] ramp frames");
        startRun();
        for (int k = 0; k < 26; k++) begin
            applyStimulus(vecs[k].inValid, int'(vecs[k].inRe), 1'b1);
            tick();
            checkOutput($sformatf("ramp valid[%0d]", k), sink_valid, vecs[k].expValid);
            if (vecs[k].expValid) begin
                expIm = ~vecs[k].expRe;
                checkOutput($sformatf("ramp sop[%0d]", k), sink_sop, vecs[k].expSop);
                checkOutput($sformatf("ramp eop[%0d]", k), sink_eop, vecs[k].expEop);
                checkOutput($sformatf("ramp real[%0d]", k), sink_real, vecs[k].expRe);
                checkOutput($sformatf("ramp imag[%0d]", k), sink_imag, expIm);
            end
        end
        drain(4);
        exp.delete();
        for (int i = 0; i < 24; i++) exp.push_back(i);
        checkBeats("ramp", exp);

        $display("[TB] backpressure");
        doReset();
        startRun();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 100 + i, !(i >= 6 && i <= 10));
            tick();
            if (i >= 5 && i <= 10) begin
                checkOutput($sformatf("hold valid[%0d]", i), sink_valid, 1);
                checkOutput($sformatf("hold real[%0d]", i), sink_real, 104);
                checkOutput($sformatf("hold sop[%0d]", i), sink_sop, 0);
            end
        end
        drain(25);
        exp.delete();
        for (int i = 0; i < 16; i++) exp.push_back(100 + i);
        checkBeats("backpressure", exp);
        checkOutput("backpressure overflow", overflow, 0);

        $display("[TB] overflow");
        doReset();
        startRun();
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 200 + i, 1'b0);
            tick();
            if (i == 15) checkOutput("overflow before full", overflow, 0);
            if (i == 16) checkOutput("overflow at first drop", overflow, 1);
        end
        checkOutput("overflow sticky", overflow, 1);
`ifdef FRAMER_DROP_CNT_EN
        checkOutput("drop_cnt", drop_cnt, 24);
`endif
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 300 + i, 1'b1);
            tick();
        end
        drain(25);
        exp.delete();
        for (int i = 0; i < 16; i++) exp.push_back(200 + i);
        for (int i = 0; i < 16; i++) exp.push_back(300 + i);
        checkBeats("overflow", exp);
`ifdef FRAMER_DROP_CNT_EN
        checkOutput("drop_cnt after release", drop_cnt, 24);
`endif

        $display("[TB] enable drop");
        doReset();
        startRun();
        for (int i = 0; i < 12; i++) begin
            if (i == 3) en = 1'b0;
            applyStimulus(1'b1, 400 + i, 1'b1);
            tick();
            if (i == 4) checkOutput("en busy mid-frame", busy, 1);
            if (i == 8) checkOutput("en busy draining", busy, 1);
            if (i == 9) checkOutput("en busy drained", busy, 0);
        end
        drain(6);
        checkOutput("en busy idle", busy, 0);
        exp.delete();
        for (int i = 0; i < 8; i++) exp.push_back(400 + i);
        checkBeats("en", exp);
        checkOutput("en overflow", overflow, 0);

        $display("[TB] reset mid-frame");
        doReset();
        startRun();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 500 + i, 1'b1);
            tick();
        end
        applyStimulus(1'b1, 505, 1'b1);
        reset_n = 1'b0;
        #1;
        checkAllZero("midreset");
        tick();
        applyStimulus(1'b0, 0, 1'b1);
        reset_n = 1'b1;
        tick();
        beats.delete();
        startRun();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 600 + i, 1'b1);
            tick();
        end
        drain(6);
        exp.delete();
        for (int i = 0; i < 8; i++) exp.push_back(600 + i);
        checkBeats("after reset", exp);

        $display("[TB] bursty input");
        doReset();
        startRun();
        for (int c = 0; c < 72; c++) begin
            applyStimulus((c % 3) == 0, 700 + c / 3, 1'($urandom_range(0, 1)));
            tick();
        end
        drain(40);
        exp.delete();
        for (int i = 0; i < 24; i++) exp.push_back(700 + i);
        checkBeats("bursty", exp);
        checkOutput("bursty overflow", overflow, 0);
`ifdef FRAMER_DROP_CNT_EN
        checkOutput("bursty drop_cnt", drop_cnt, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
